// File: rtl/clock_count_pkg.sv
// Shared constants for the AXI4-Lite reader of the RSA cycle counter:
// register offsets, response codes and FSM state encodings.
package clock_count_pkg;

   localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
   localparam logic [31:0] ADDR_CNT_W0 = 32'h0000_0010;
   localparam logic [31:0] ADDR_CNT_W1 = 32'h0000_0014;
   localparam logic [31:0] ADDR_CNT_W2 = 32'h0000_0018;
   localparam logic [31:0] ADDR_CNT_W3 = 32'h0000_001C;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int CTRL_CLEAR_BIT = 0;

   localparam logic W_IDLE = 1'b0;
   localparam logic W_RESP = 1'b1;
   localparam logic R_IDLE = 1'b0;
   localparam logic R_DATA = 1'b1;

endpackage

// File: rtl/clock_count_axil.sv
// AXI4-Lite register reader for the free-running cycle counter: coherent
// four-word readout through a shadow register and a clear control bit.
module clock_count_axil
   import clock_count_pkg::*;
#(
   parameter int COUNTER_LENGTH = 128,
   parameter int ADDR_WIDTH     = 5
) (
   input  logic                      CLOCK,
   input  logic                      RESET,
   input  logic [COUNTER_LENGTH-1:0] COUNT_IN,
   output logic                      CNT_CLEAR,
   input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic                      S_AXI_AWVALID,
   output logic                      S_AXI_AWREADY,
   input  logic [31:0]               S_AXI_WDATA,
   input  logic [3:0]                S_AXI_WSTRB,
   input  logic                      S_AXI_WVALID,
   output logic                      S_AXI_WREADY,
   output logic [1:0]                S_AXI_BRESP,
   output logic                      S_AXI_BVALID,
   input  logic                      S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic                      S_AXI_ARVALID,
   output logic                      S_AXI_ARREADY,
   output logic [31:0]               S_AXI_RDATA,
   output logic [1:0]                S_AXI_RRESP,
   output logic                      S_AXI_RVALID,
   input  logic                      S_AXI_RREADY
);

   logic          w_state_r;
   logic          bvalid_r;
   logic [1:0]    bresp_r;
   logic          clear_r;
   logic          r_state_r;
   logic          arready_r;
   logic          rvalid_r;
   logic [31:0]   rdata_r;
   logic [1:0]    rresp_r;
   logic [127:32] shadow_r;
   logic          shadow_valid_r;

   logic [127:0]  count_ext_s;
   logic [31:0]   awaddr_s;
   logic [31:0]   araddr_s;
   logic          w_hs_s;
   logic          ctrl_wr_s;
   logic          clear_req_s;
   logic [1:0]    bresp_s;
   logic          r_hs_s;
   logic          capture_s;
   logic [31:0]   rdata_s;
   logic [1:0]    rresp_s;
   logic          unused_s;

   assign unused_s = ^{S_AXI_WDATA[31:1], S_AXI_WSTRB[3:1], S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Zero-extend the counter and normalise both addresses to word offsets.
   always_comb begin
      count_ext_s                        = 128'h0;
      count_ext_s[COUNTER_LENGTH-1:0]    = COUNT_IN;
      awaddr_s                           = 32'h0;
      awaddr_s[ADDR_WIDTH-1:2]           = S_AXI_AWADDR[ADDR_WIDTH-1:2];
      araddr_s                           = 32'h0;
      araddr_s[ADDR_WIDTH-1:2]           = S_AXI_ARADDR[ADDR_WIDTH-1:2];
   end

   // Write acceptance and CTRL decode; AW and W are only taken together.
   always_comb begin
      w_hs_s      = (w_state_r == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID && !RESET;
      ctrl_wr_s   = (awaddr_s == ADDR_CTRL);
      clear_req_s = w_hs_s && ctrl_wr_s && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_CLEAR_BIT];
      if (ctrl_wr_s) begin
         bresp_s = RESP_OKAY;
      end else begin
         bresp_s = RESP_SLVERR;
      end
   end

   // Read decode; a W0 read samples the live counter and snapshots the rest.
   always_comb begin
      r_hs_s    = S_AXI_ARVALID && arready_r;
      capture_s = r_hs_s && (araddr_s == ADDR_CNT_W0);
      rdata_s   = 32'h0;
      rresp_s   = RESP_OKAY;
      case (araddr_s)
         ADDR_CTRL:   rdata_s = {31'h0, shadow_valid_r};
         ADDR_CNT_W0: rdata_s = count_ext_s[31:0];
         ADDR_CNT_W1: rdata_s = shadow_r[63:32];
         ADDR_CNT_W2: rdata_s = shadow_r[95:64];
         ADDR_CNT_W3: rdata_s = shadow_r[127:96];
         default:     rresp_s = RESP_SLVERR;
      endcase
   end

   // Write response channel and the one-cycle clear pulse.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         w_state_r <= W_IDLE;
         bvalid_r  <= 1'b0;
         bresp_r   <= RESP_OKAY;
         clear_r   <= 1'b0;
      end else begin
         clear_r <= clear_req_s;
         case (w_state_r)
            W_IDLE: begin
               if (w_hs_s) begin
                  w_state_r <= W_RESP;
                  bvalid_r  <= 1'b1;
                  bresp_r   <= bresp_s;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  w_state_r <= W_IDLE;
                  bvalid_r  <= 1'b0;
               end
            end
            default: begin
               w_state_r <= W_IDLE;
               bvalid_r  <= 1'b0;
            end
         endcase
      end
   end

   // Read data channel; ARREADY is held low while a response is pending.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_state_r <= R_IDLE;
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= 32'h0;
         rresp_r   <= RESP_OKAY;
      end else begin
         case (r_state_r)
            R_IDLE: begin
               if (r_hs_s) begin
                  r_state_r <= R_DATA;
                  arready_r <= 1'b0;
                  rvalid_r  <= 1'b1;
                  rdata_r   <= rdata_s;
                  rresp_r   <= rresp_s;
               end else begin
                  arready_r <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  r_state_r <= R_IDLE;
                  arready_r <= 1'b1;
                  rvalid_r  <= 1'b0;
               end
            end
            default: begin
               r_state_r <= R_IDLE;
               arready_r <= 1'b0;
               rvalid_r  <= 1'b0;
            end
         endcase
      end
   end

   // Shadow of the upper words; a clear on either edge overrides a capture.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         shadow_r       <= 96'h0;
         shadow_valid_r <= 1'b0;
      end else if (clear_req_s || clear_r) begin
         shadow_r       <= 96'h0;
         shadow_valid_r <= 1'b0;
      end else if (capture_s) begin
         shadow_r       <= count_ext_s[127:32];
         shadow_valid_r <= 1'b1;
      end
   end

   assign CNT_CLEAR     = clear_r;
   assign S_AXI_AWREADY = w_hs_s;
   assign S_AXI_WREADY  = w_hs_s;
   assign S_AXI_BVALID  = bvalid_r;
   assign S_AXI_BRESP   = bresp_r;
   assign S_AXI_ARREADY = arready_r;
   assign S_AXI_RVALID  = rvalid_r;
   assign S_AXI_RDATA   = rdata_r;
   assign S_AXI_RRESP   = rresp_r;

endmodule

// File: tb/tb_clock_count_axil.sv
// Scoreboard bench for clock_count_axil: directed register-map cases, then
// randomized reads/writes checked against a word-level register model.
module tb_clock_count_axil;
   import clock_count_pkg::*;

   logic         CLOCK = 1'b0;
   logic         RESET = 1'b1;
   logic [127:0] COUNT_IN = 128'h0;
   logic         CNT_CLEAR;
   logic [4:0]   AWADDR = 5'h0;
   logic         AWVALID = 1'b0, AWREADY;
   logic [31:0]  WDATA = 32'h0;
   logic [3:0]   WSTRB = 4'h0;
   logic         WVALID = 1'b0, WREADY;
   logic [1:0]   BRESP;
   logic         BVALID, BREADY = 1'b0;
   logic [4:0]   ARADDR = 5'h0;
   logic         ARVALID = 1'b0, ARREADY;
   logic [31:0]  RDATA;
   logic [1:0]   RRESP;
   logic         RVALID, RREADY = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [33:0] rq[$];
   logic [1:0]  bq[$];
   logic [33:0] mon_r;
   logic [1:0]  mon_b;

   logic [31:0] m_shadow [1:3];
   logic        m_valid;

   clock_count_axil #(.COUNTER_LENGTH(128), .ADDR_WIDTH(5)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .COUNT_IN(COUNT_IN), .CNT_CLEAR(CNT_CLEAR),
      .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
      .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
      .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
      .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
      .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Register model: CTRL reports snapshot validity, W0 snapshots the upper words.
   task automatic model_read(input logic [4:0] a, output logic [33:0] e);
      case (a & 5'h1C)
         5'h00: e = {RESP_OKAY, 31'h0, m_valid};
         5'h10: begin
            e = {RESP_OKAY, COUNT_IN[31:0]};
            m_shadow[1] = COUNT_IN[63:32];
            m_shadow[2] = COUNT_IN[95:64];
            m_shadow[3] = COUNT_IN[127:96];
            m_valid = 1'b1;
         end
         5'h14: e = {RESP_OKAY, m_shadow[1]};
         5'h18: e = {RESP_OKAY, m_shadow[2]};
         5'h1C: e = {RESP_OKAY, m_shadow[3]};
         default: e = {RESP_SLVERR, 32'h0};
      endcase
   endtask

   task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] resp, output logic clr);
      clr = 1'b0;
      if ((a & 5'h1C) == 5'h00) begin
         resp = RESP_OKAY;
         if (s[0] && d[0]) begin
            clr = 1'b1;
            m_shadow[1] = 32'h0;
            m_shadow[2] = 32'h0;
            m_shadow[3] = 32'h0;
            m_valid = 1'b0;
         end
      end else begin
         resp = RESP_SLVERR;
      end
   endtask

   // Monitor: pops the scoreboard on every completed R or B handshake.
   always @(negedge CLOCK) begin
      if (!RESET) begin
         if (RVALID && RREADY) begin
            if (rq.size() == 0) begin
               check("r_unexpected", 1'b1, 1'b0);
            end else begin
               mon_r = rq.pop_front();
               check("rdata", RDATA, mon_r[31:0]);
               check("rresp", RRESP, mon_r[33:32]);
            end
         end
         if (BVALID && BREADY) begin
            if (bq.size() == 0) begin
               check("b_unexpected", 1'b1, 1'b0);
            end else begin
               mon_b = bq.pop_front();
               check("bresp", BRESP, mon_b);
            end
         end
      end
   end

   task automatic wait_aw();
      int n = 0;
      @(negedge CLOCK);
      while (!AWREADY && n < 20) begin
         n++;
         @(negedge CLOCK);
      end
      check("aw_accept", AWREADY, 1'b1);
      check("wready_with_aw", WREADY, 1'b1);
   endtask

   task automatic do_read(input logic [4:0] a, input int rdly);
      logic [33:0] e;
      int n = 0;
      model_read(a, e);
      rq.push_back(e);
      @(posedge CLOCK); #1;
      ARADDR = a;
      ARVALID = 1'b1;
      @(negedge CLOCK);
      while (!ARREADY && n < 20) begin
         n++;
         @(negedge CLOCK);
      end
      check("ar_accept", ARREADY, 1'b1);
      @(posedge CLOCK); #1;
      ARVALID = 1'b0;
      for (int i = 0; i < rdly; i++) begin
         @(negedge CLOCK);
         check("r_hold_valid", RVALID, 1'b1);
         check("r_hold_data", RDATA, e[31:0]);
         check("r_hold_arready", ARREADY, 1'b0);
         @(posedge CLOCK); #1;
      end
      RREADY = 1'b1;
      @(negedge CLOCK);
      check("rvalid", RVALID, 1'b1);
      @(posedge CLOCK); #1;
      RREADY = 1'b0;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input int bdly);
      logic [1:0] resp;
      logic clr;
      model_write(a, d, s, resp, clr);
      bq.push_back(resp);
      @(posedge CLOCK); #1;
      AWADDR = a; WDATA = d; WSTRB = s;
      AWVALID = 1'b1; WVALID = 1'b1;
      wait_aw();
      @(posedge CLOCK); #1;
      AWVALID = 1'b0; WVALID = 1'b0;
      @(negedge CLOCK);
      check("cnt_clear", CNT_CLEAR, clr);
      check("bvalid", BVALID, 1'b1);
      @(negedge CLOCK);
      check("cnt_clear_pulse_end", CNT_CLEAR, 1'b0);
      for (int i = 0; i < bdly; i++) begin
         @(negedge CLOCK);
         check("b_hold_valid", BVALID, 1'b1);
      end
      @(posedge CLOCK); #1;
      BREADY = 1'b1;
      @(negedge CLOCK);
      check("bvalid_at_ready", BVALID, 1'b1);
      @(posedge CLOCK); #1;
      BREADY = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] resp;
      logic       clr;
      logic [4:0] a;
      m_shadow[1] = 32'h0; m_shadow[2] = 32'h0; m_shadow[3] = 32'h0;
      m_valid = 1'b0;

      // Reset with valids asserted: nothing may be accepted.
      RESET = 1'b1;
      AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLOCK);
         check("rst_awready", AWREADY, 1'b0);
         check("rst_wready", WREADY, 1'b0);
         check("rst_arready", ARREADY, 1'b0);
         check("rst_bvalid", BVALID, 1'b0);
         check("rst_rvalid", RVALID, 1'b0);
         check("rst_cnt_clear", CNT_CLEAR, 1'b0);
         check("rst_rdata", RDATA, 32'h0);
      end
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLOCK);
         @(negedge CLOCK);
         check("idle_arready", ARREADY, 1'b1);
         check("idle_rdata", RDATA, 32'h0);
         check("idle_bvalid", BVALID, 1'b0);
      end

      // Coherent readout: upper words come from the W0 snapshot.
      COUNT_IN = 128'h0000000D_0000000C_0000000B_0000000A;
      do_read(5'h10, 0);
      COUNT_IN = {$urandom, $urandom, $urandom, $urandom};
      do_read(5'h14, 0);
      do_read(5'h18, 1);
      do_read(5'h1C, 0);
      do_read(5'h00, 0);

      // Clear, then a write with the low strobe off.
      do_write(5'h00, 32'h1, 4'hF, 0);
      do_read(5'h00, 0);
      do_read(5'h14, 0);
      do_read(5'h10, 0);
      do_write(5'h00, 32'h1, 4'h0, 0);
      do_read(5'h00, 0);

      // Unmapped read, write to read-only word.
      do_read(5'h08, 0);
      do_write(5'h10, 32'hFFFF_FFFF, 4'hF, 0);
      do_read(5'h14, 0);

      // Backpressure on R, then on B with a second AW/W pair waiting.
      do_read(5'h18, 5);
      do_write(5'h00, 32'h0, 4'hF, 2);
      model_write(5'h00, 32'h0, 4'hF, resp, clr);
      bq.push_back(resp);
      @(posedge CLOCK); #1;
      AWADDR = 5'h00; WDATA = 32'h0; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1;
      wait_aw();
      @(posedge CLOCK); #1;
      AWADDR = 5'h10; WDATA = $urandom;
      model_write(5'h10, WDATA, 4'hF, resp, clr);
      bq.push_back(resp);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLOCK);
         check("bp_bvalid_held", BVALID, 1'b1);
         check("bp_aw_blocked", AWREADY, 1'b0);
         check("bp_w_blocked", WREADY, 1'b0);
      end
      @(posedge CLOCK); #1;
      BREADY = 1'b1;
      @(negedge CLOCK);
      check("bp_aw_blocked_at_b", AWREADY, 1'b0);
      @(posedge CLOCK);
      @(negedge CLOCK);
      check("bp_aw_after_b", AWREADY, 1'b1);
      @(posedge CLOCK); #1;
      AWVALID = 1'b0; WVALID = 1'b0;
      @(negedge CLOCK);
      check("bp_second_bvalid", BVALID, 1'b1);
      @(posedge CLOCK); #1;
      BREADY = 1'b0;
      do_read(5'h14, 0);

      // Randomized mix of reads and writes.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 1) == 1) COUNT_IN = {$urandom, $urandom, $urandom, $urandom};
         a = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) begin
            do_write(a, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
         end else begin
            if ($urandom_range(0, 2) == 0) a = 5'h10;
            do_read(a, $urandom_range(0, 3));
         end
      end

      repeat (4) @(posedge CLOCK);
      check("r_queue_drained", 32'(rq.size()), 32'h0);
      check("b_queue_drained", 32'(bq.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
